cordic_vector_unroll_var: RTL and testbench

// - Vectoring-mode CORDIC, the inverse of the rotation-mode cosine unit: takes a fixed-point vector (x,y) and returns its angle atan2(y,x) and its CORDIC-scaled magnitude.
// - Iterative over 16 micro-rotations with UNROLLS stages per clock; uses the same start/done custom-instruction handshake as the cosine units.
// - Intended for phase recovery / arccos post-processing in the same accelerator.

---
 rtl/cordic_vector_unroll_var.sv | 149 ++++++++++++++
 tb/tb_cordic_vector_unroll_var.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector_unroll_var.sv
// Vectoring-mode CORDIC: atan2(y,x) and K-scaled magnitude of a Q1.20 vector,
// 16 micro-rotations, UNROLLS of them per enabled clock, start/done handshake.
module cordic_vector_unroll_var #(
    parameter int unsigned UNROLLS = 2
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic [31:0] result_mag,
    output logic        done
);

    localparam int unsigned OW    = 32;
    localparam int unsigned IW    = 21;
    localparam int unsigned DW    = 24;
    localparam int unsigned CW    = 5;
    localparam int unsigned NITER = 16;

    localparam logic signed [DW-1:0] PI = 24'sh3243F7;
    localparam logic signed [DW-1:0] ATAN [NITER] = '{
        24'sh0C90FE, 24'sh076B1A, 24'sh03EB6F, 24'sh01FD5C,
        24'sh00FFAB, 24'sh007FF5, 24'sh003FFF, 24'sh002000,
        24'sh001000, 24'sh000800, 24'sh000400, 24'sh000200,
        24'sh000100, 24'sh000080, 24'sh000040, 24'sh000020
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic signed [DW-1:0] r_x, r_y, r_z;
    logic signed [DW-1:0] w_x_nxt, w_y_nxt, w_z_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic                 r_zero, w_zero_nxt;
    logic                 r_done, w_done_nxt;
    logic [OW-1:0]        r_result, w_result_nxt;
    logic [OW-1:0]        r_mag, w_mag_nxt;

    logic signed [DW-1:0] w_ax, w_ay;
    logic signed [DW-1:0] w_sx, w_sy, w_sz;
    logic signed [DW-1:0] w_dx, w_dy;
    logic [3:0]           w_idx;
    logic                 w_unused;

    assign w_ax     = {{(DW-IW){dataa[IW-1]}}, dataa[IW-1:0]};
    assign w_ay     = {{(DW-IW){datab[IW-1]}}, datab[IW-1:0]};
    assign w_unused = ^{dataa[OW-1:IW], datab[OW-1:IW]};

    // UNROLLS chained micro-rotations; every shift uses the pre-stage x and y
    always_comb begin : stage_chain
        w_sx  = r_x;
        w_sy  = r_y;
        w_sz  = r_z;
        w_idx = '0;
        w_dx  = '0;
        w_dy  = '0;
        for (int k = 0; k < int'(UNROLLS); k++) begin
            w_idx = r_cnt[3:0] + 4'(k);
            w_dx  = w_sy >>> w_idx;
            w_dy  = w_sx >>> w_idx;
            if (!w_sy[DW-1]) begin
                w_sx = w_sx + w_dx;
                w_sy = w_sy - w_dy;
                w_sz = w_sz + ATAN[w_idx];
            end else begin
                w_sx = w_sx - w_dx;
                w_sy = w_sy + w_dy;
                w_sz = w_sz - ATAN[w_idx];
            end
        end
    end

    always_comb begin : fsm_next
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_z_nxt      = r_z;
        w_cnt_nxt    = r_cnt;
        w_zero_nxt   = r_zero;
        w_done_nxt   = r_done;
        w_result_nxt = r_result;
        w_mag_nxt    = r_mag;
        if (start) begin
            // Left half-plane is folded onto the right by a +/-PI pre-rotation
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_zero_nxt  = (w_ax == '0) && (w_ay == '0);
            if (w_ax[DW-1]) begin
                w_x_nxt = -w_ax;
                w_y_nxt = -w_ay;
                w_z_nxt = w_ay[DW-1] ? -PI : PI;
            end else begin
                w_x_nxt = w_ax;
                w_y_nxt = w_ay;
                w_z_nxt = '0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    w_x_nxt   = w_sx;
                    w_y_nxt   = w_sy;
                    w_z_nxt   = w_sz;
                    w_cnt_nxt = r_cnt + CW'(UNROLLS);
                    if (w_cnt_nxt == CW'(NITER)) begin
                        w_state_nxt  = S_DONE;
                        w_done_nxt   = 1'b1;
                        w_result_nxt = r_zero ? '0 : {{(OW-DW){w_sz[DW-1]}}, w_sz};
                        w_mag_nxt    = r_zero ? '0 : {{(OW-DW){1'b0}}, w_sx};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_mag    <= '0;
        end else if (clk_en) begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_z      <= w_z_nxt;
            r_cnt    <= w_cnt_nxt;
            r_zero   <= w_zero_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_mag    <= w_mag_nxt;
        end
    end

    assign result     = r_result;
    assign result_mag = r_mag;
    assign done       = r_done;

endmodule

// File: tb/tb_cordic_vector_unroll_var.sv
// Bench for cordic_vector_unroll_var: five instances (UNROLLS 1,2,4,8,16) on shared
// inputs, checked against an arithmetic CORDIC model and real-valued atan2/|v|*K.
module tb_cordic_vector_unroll_var;

    localparam int NU = 5;
    localparam int UNR [NU] = '{1, 2, 4, 8, 16};
    localparam int ATAN_T [16] = '{
        32'h0C90FE, 32'h076B1A, 32'h03EB6F, 32'h01FD5C, 32'h00FFAB, 32'h007FF5,
        32'h003FFF, 32'h002000, 32'h001000, 32'h000800, 32'h000400, 32'h000200,
        32'h000100, 32'h000080, 32'h000040, 32'h000020};
    localparam real ONE   = 1048576.0;
    localparam real KGAIN = 1.646760258;
    // Residual after the last micro-rotation can reach ATAN[15] plus truncation
    localparam real TOL_ANG = 32.0;
    localparam real TOL_MAG = 48.0;

    logic        clock = 1'b0;
    logic        aclr, clk_en, start;
    logic [31:0] dataa, datab;
    logic [31:0] res_w [NU];
    logic [31:0] mag_w [NU];
    logic        done_w [NU];
    int          lat [NU];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    cordic_vector_unroll_var #(.UNROLLS(1)) u_dut1 (.clock(clock), .aclr(aclr), .clk_en(clk_en),
        .start(start), .dataa(dataa), .datab(datab), .result(res_w[0]), .result_mag(mag_w[0]), .done(done_w[0]));
    cordic_vector_unroll_var #(.UNROLLS(2)) u_dut2 (.clock(clock), .aclr(aclr), .clk_en(clk_en),
        .start(start), .dataa(dataa), .datab(datab), .result(res_w[1]), .result_mag(mag_w[1]), .done(done_w[1]));
    cordic_vector_unroll_var #(.UNROLLS(4)) u_dut4 (.clock(clock), .aclr(aclr), .clk_en(clk_en),
        .start(start), .dataa(dataa), .datab(datab), .result(res_w[2]), .result_mag(mag_w[2]), .done(done_w[2]));
    cordic_vector_unroll_var #(.UNROLLS(8)) u_dut8 (.clock(clock), .aclr(aclr), .clk_en(clk_en),
        .start(start), .dataa(dataa), .datab(datab), .result(res_w[3]), .result_mag(mag_w[3]), .done(done_w[3]));
    cordic_vector_unroll_var #(.UNROLLS(16)) u_dut16 (.clock(clock), .aclr(aclr), .clk_en(clk_en),
        .start(start), .dataa(dataa), .datab(datab), .result(res_w[4]), .result_mag(mag_w[4]), .done(done_w[4]));

    function automatic int sext21(input logic [31:0] v);
        return int'({{11{v[20]}}, v[20:0]});
    endfunction

    // Sixteen sequential micro-rotations on plain integers
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [31:0] m);
        int x, y, z, t;
        bit zero;
        x = sext21(a);
        y = sext21(b);
        zero = (x == 0) && (y == 0);
        z = 0;
        if (x < 0) begin
            z = (y >= 0) ? 32'sh3243F7 : -32'sh3243F7;
            x = -x;
            y = -y;
        end
        for (int i = 0; i < 16; i++) begin
            t = x;
            if (y >= 0) begin
                x = x + (y >>> i); y = y - (t >>> i); z = z + ATAN_T[i];
            end else begin
                x = x - (y >>> i); y = y + (t >>> i); z = z - ATAN_T[i];
            end
        end
        r = zero ? 32'd0 : 32'(z);
        m = zero ? 32'd0 : 32'(x);
    endfunction

    function automatic real ideal_ang(input int x, input int y);
        return $atan2(real'(y), real'(x)) * ONE;
    endfunction

    function automatic real ideal_mag(input int x, input int y);
        return $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * KGAIN;
    endfunction

    // Edge at which done should rise, counting only clk_en-high edges
    function automatic int exp_lat(input int u, input int stall_at, input int stall_len);
        int cnt;
        cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!(c >= stall_at && c < stall_at + stall_len)) cnt++;
            if (cnt == 16 / u) return c;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int stall_at, input int stall_len);
        bit all_set;
        for (int k = 0; k < NU; k++) lat[k] = 0;
        for (int c = 1; c <= 40; c++) begin
            clk_en = !(c >= stall_at && c < stall_at + stall_len);
            tick();
            all_set = 1'b1;
            for (int k = 0; k < NU; k++) begin
                if (lat[k] == 0 && done_w[k] === 1'b1) lat[k] = c;
                if (lat[k] == 0) all_set = 1'b0;
            end
            if (all_set) break;
        end
        clk_en = 1'b1;
    endtask

    task automatic test_reset();
        aclr = 1'b1; clk_en = 1'b0; start = 1'b1;
        dataa = 32'h080000; datab = 32'h080000;
        repeat (3) tick();
        aclr = 1'b0; start = 1'b0; clk_en = 1'b1;
        for (int k = 0; k < NU; k++) begin
            n_checks++;
            if (done_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset done U=%0d: got %b want 0", UNR[k], done_w[k]); end
            n_checks++;
            if (res_w[k] !== 32'd0) begin n_fail++; $display("FAIL reset result U=%0d: got %h want 0", UNR[k], res_w[k]); end
            n_checks++;
            if (mag_w[k] !== 32'd0) begin n_fail++; $display("FAIL reset mag U=%0d: got %h want 0", UNR[k], mag_w[k]); end
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [4] = '{32'h080000, 32'h100000, 32'h000000, 32'h0FFFFF};
        logic [31:0] vb [4] = '{32'h080000, 32'h000000, 32'h180000, 32'h0FFFFF};
        logic [31:0] er, em;
        real d;
        for (int v = 0; v < 4; v++) begin
            issue(va[v], vb[v]);
            wait_done(0, 0);
            ref_model(va[v], vb[v], er, em);
            for (int k = 0; k < NU; k++) begin
                n_checks++;
                if (lat[k] != exp_lat(UNR[k], 0, 0)) begin n_fail++;
                    $display("FAIL vec%0d latency U=%0d: got %0d want %0d", v, UNR[k], lat[k], exp_lat(UNR[k], 0, 0)); end
                n_checks++;
                if (res_w[k] !== er) begin n_fail++; $display("FAIL vec%0d result U=%0d: got %h want %h", v, UNR[k], res_w[k], er); end
                n_checks++;
                if (mag_w[k] !== em) begin n_fail++; $display("FAIL vec%0d mag U=%0d: got %h want %h", v, UNR[k], mag_w[k], em); end
            end
            d = real'(int'(res_w[1])) - ideal_ang(sext21(va[v]), sext21(vb[v]));
            n_checks++;
            if (d > TOL_ANG || d < -TOL_ANG) begin n_fail++; $display("FAIL vec%0d angle accuracy: got %h off by %f LSB", v, res_w[1], d); end
            d = real'(int'(mag_w[1])) - ideal_mag(sext21(va[v]), sext21(vb[v]));
            n_checks++;
            if (d > TOL_MAG || d < -TOL_MAG) begin n_fail++; $display("FAIL vec%0d mag accuracy: got %h off by %f LSB", v, mag_w[1], d); end
            repeat (3) tick();
            n_checks++;
            if (done_w[1] !== 1'b1 || res_w[1] !== er) begin n_fail++;
                $display("FAIL vec%0d hold: done %b result %h want 1 %h", v, done_w[1], res_w[1], er); end
        end
    endtask

    task automatic test_zero();
        logic [31:0] er, em;
        real d;
        issue(32'h0, 32'h0);
        wait_done(0, 0);
        for (int k = 0; k < NU; k++) begin
            n_checks++;
            if (lat[k] != 16 / UNR[k]) begin n_fail++; $display("FAIL zero latency U=%0d: got %0d want %0d", UNR[k], lat[k], 16 / UNR[k]); end
            n_checks++;
            if (res_w[k] !== 32'd0 || mag_w[k] !== 32'd0) begin n_fail++;
                $display("FAIL zero output U=%0d: got %h/%h want 0/0", UNR[k], res_w[k], mag_w[k]); end
        end
        issue(32'h0FFFFF, 32'h0FFFFF);
        wait_done(0, 0);
        ref_model(32'h0FFFFF, 32'h0FFFFF, er, em);
        d = real'(int'(res_w[1])) - real'(32'h0C90FE);
        n_checks++;
        if (d > TOL_ANG || d < -TOL_ANG) begin n_fail++; $display("FAIL after-zero angle: got %h want ~000C90FE", res_w[1]); end
        n_checks++;
        if (mag_w[1] !== em) begin n_fail++; $display("FAIL after-zero mag: got %h want %h", mag_w[1], em); end
    endtask

    task automatic test_stall();
        logic [31:0] er, em;
        issue(32'h080000, 32'h080000);
        wait_done(4, 3);
        ref_model(32'h080000, 32'h080000, er, em);
        for (int k = 0; k < NU; k++) begin
            n_checks++;
            if (lat[k] != exp_lat(UNR[k], 4, 3)) begin n_fail++;
                $display("FAIL stall latency U=%0d: got %0d want %0d", UNR[k], lat[k], exp_lat(UNR[k], 4, 3)); end
            n_checks++;
            if (res_w[k] !== er) begin n_fail++; $display("FAIL stall result U=%0d: got %h want %h", UNR[k], res_w[k], er); end
        end
    endtask

    task automatic test_restart();
        logic [31:0] er, em;
        issue(32'h100000, 32'h000000);
        repeat (3) tick();
        issue(32'h000000, 32'h180000);
        wait_done(0, 0);
        ref_model(32'h000000, 32'h180000, er, em);
        for (int k = 0; k < NU; k++) begin
            n_checks++;
            if (lat[k] != 16 / UNR[k]) begin n_fail++; $display("FAIL restart latency U=%0d: got %0d want %0d", UNR[k], lat[k], 16 / UNR[k]); end
            n_checks++;
            if (res_w[k] !== er || mag_w[k] !== em) begin n_fail++;
                $display("FAIL restart output U=%0d: got %h/%h want %h/%h", UNR[k], res_w[k], mag_w[k], er, em); end
        end
    endtask

    task automatic test_aclr_mid();
        logic [31:0] er, em;
        bit seen;
        issue(32'h080000, 32'h080000);
        repeat (4) tick();
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        for (int k = 0; k < NU; k++) begin
            n_checks++;
            if (done_w[k] !== 1'b0 || res_w[k] !== 32'd0 || mag_w[k] !== 32'd0) begin n_fail++;
                $display("FAIL aclr U=%0d: done %b result %h mag %h want 0", UNR[k], done_w[k], res_w[k], mag_w[k]); end
        end
        seen = 1'b0;
        repeat (20) begin
            tick();
            for (int k = 0; k < NU; k++) if (done_w[k] !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL aclr abandon: done rose without start, got 1 want 0"); end
        issue(32'h1C0000, 32'h040000);
        wait_done(0, 0);
        ref_model(32'h1C0000, 32'h040000, er, em);
        n_checks++;
        if (lat[1] != 8 || res_w[1] !== er) begin n_fail++;
            $display("FAIL aclr rerun: latency %0d result %h want 8 %h", lat[1], res_w[1], er); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, er, em;
        for (int n = 0; n < 3; n++) begin
            a = $urandom();
            b = $urandom();
            issue(a, b);
            for (int k = 0; k < NU; k++) begin
                n_checks++;
                if (done_w[k] !== 1'b0) begin n_fail++; $display("FAIL b2b drop U=%0d: done %b want 0", UNR[k], done_w[k]); end
            end
            wait_done(0, 0);
            ref_model(a, b, er, em);
            n_checks++;
            if (res_w[1] !== er || mag_w[1] !== em) begin n_fail++;
                $display("FAIL b2b output: got %h/%h want %h/%h", res_w[1], mag_w[1], er, em); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, er, em;
        int x, y;
        real d;
        for (int n = 0; n < 40; n++) begin
            a = $urandom();
            b = $urandom();
            if (n % 8 == 3) a[20:0] = 21'h100000;
            if (n % 8 == 5) b[20:0] = 21'h0;
            issue(a, b);
            wait_done(0, 0);
            ref_model(a, b, er, em);
            for (int k = 0; k < NU; k++) begin
                n_checks++;
                if (lat[k] != 16 / UNR[k] || res_w[k] !== er || mag_w[k] !== em) begin n_fail++;
                    $display("FAIL random%0d U=%0d: lat %0d out %h/%h want %0d %h/%h",
                             n, UNR[k], lat[k], res_w[k], mag_w[k], 16 / UNR[k], er, em); end
            end
            x = sext21(a);
            y = sext21(b);
            if (ideal_mag(x, y) / KGAIN >= 0.25 * ONE) begin
                d = real'(int'(res_w[1])) - ideal_ang(x, y);
                n_checks++;
                if (d > TOL_ANG || d < -TOL_ANG) begin n_fail++;
                    $display("FAIL random%0d angle accuracy: got %h off by %f LSB", n, res_w[1], d); end
            end
        end
    endtask

    initial begin
        aclr = 1'b1; clk_en = 1'b0; start = 1'b0; dataa = '0; datab = '0;
        test_reset();
        test_vectors();
        test_zero();
        test_stall();
        test_restart();
        test_aclr_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
